pong_score_ctrl: RTL and testbench

PONG_SCORE_CTRL -- requirements
Module: pong_score_ctrl

---
 rtl/pong_score_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pong_score_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_ctrl.sv
// Pong game sequencer: serve/launch handshake, point scoring with a post-point
// pause measured in frame ticks, and game-over detection. All outputs are flops.
module pong_score_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic [1:0] serve_n,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       ball_enable,
    output logic       serve_pulse,
    output logic       serve_dir,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
    localparam logic [7:0] PAUSE = 8'(PAUSE_FRAMES);

    logic [2:0] state_q, state_d;
    logic [1:0] btn_prev_q, btn_prev_d;
    logic [3:0] score_p1_q, score_p1_d;
    logic [3:0] score_p2_q, score_p2_d;
    logic       server_p2_q, server_p2_d;
    logic [7:0] pause_cnt_q, pause_cnt_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_pulse_q, serve_pulse_d;
    logic       serve_dir_q, serve_dir_d;
    logic       ball_enable_q, ball_enable_d;
    logic       game_over_q, game_over_d;

    logic [1:0] press;
    logic       pause_done;
    logic       someone_won;

    // press[1] = player 1, press[0] = player 2; one cycle per falling edge
    assign press       = btn_prev_q & ~serve_n;
    assign pause_done  = frame_tick && ((pause_cnt_q + 8'd1) == PAUSE);
    assign someone_won = (score_p1_q == WIN) || (score_p2_q == WIN);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_IDLE;
            btn_prev_q    <= 2'b11;
            score_p1_q    <= 4'd0;
            score_p2_q    <= 4'd0;
            server_p2_q   <= 1'b0;
            pause_cnt_q   <= 8'd0;
            winner_q      <= 2'b00;
            serve_pulse_q <= 1'b0;
            serve_dir_q   <= 1'b0;
            ball_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_prev_q    <= btn_prev_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            server_p2_q   <= server_p2_d;
            pause_cnt_q   <= pause_cnt_d;
            winner_q      <= winner_d;
            serve_pulse_q <= serve_pulse_d;
            serve_dir_q   <= serve_dir_d;
            ball_enable_q <= ball_enable_d;
            game_over_q   <= game_over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|press) state_d = S_PLAY;
            S_SERVE: if (server_p2_q ? press[0] : press[1]) state_d = S_PLAY;
            S_PLAY: begin
                if (miss_left && miss_right)     state_d = S_SERVE;
                else if (miss_left || miss_right) state_d = S_POINT;
            end
            S_POINT: if (pause_done) state_d = someone_won ? S_OVER : S_SERVE;
            S_OVER:  if (|press) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        btn_prev_d    = serve_n;
        score_p1_d    = score_p1_q;
        score_p2_d    = score_p2_q;
        server_p2_d   = server_p2_q;
        pause_cnt_d   = pause_cnt_q;
        winner_d      = winner_q;
        serve_pulse_d = 1'b0;
        serve_dir_d   = serve_dir_q;
        case (state_q)
            S_IDLE: begin
                if (press[1]) begin
                    serve_pulse_d = 1'b1;
                    serve_dir_d   = 1'b1;
                end else if (press[0]) begin
                    serve_pulse_d = 1'b1;
                    serve_dir_d   = 1'b0;
                end
            end
            S_SERVE: begin
                if (server_p2_q && press[0]) begin
                    serve_pulse_d = 1'b1;
                    serve_dir_d   = 1'b0;
                end else if (!server_p2_q && press[1]) begin
                    serve_pulse_d = 1'b1;
                    serve_dir_d   = 1'b1;
                end
            end
            S_PLAY: begin
                if (miss_left && !miss_right) begin
                    if (score_p2_q < 4'd9) score_p2_d = score_p2_q + 4'd1;
                    server_p2_d = 1'b0;
                    pause_cnt_d = 8'd0;
                end else if (miss_right && !miss_left) begin
                    if (score_p1_q < 4'd9) score_p1_d = score_p1_q + 4'd1;
                    server_p2_d = 1'b1;
                    pause_cnt_d = 8'd0;
                end
            end
            S_POINT: begin
                if (frame_tick) pause_cnt_d = pause_cnt_q + 8'd1;
                if (pause_done && someone_won)
                    winner_d = (score_p1_q == WIN) ? 2'b01 : 2'b10;
            end
            S_OVER: begin
                if (|press) begin
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    winner_d   = 2'b00;
                end
            end
            default: ;
        endcase
        ball_enable_d = (state_d == S_PLAY);
        game_over_d   = (state_d == S_OVER);
    end

    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign ball_enable = ball_enable_q;
    assign serve_pulse = serve_pulse_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench for pong_score_ctrl with default parameters (win at 7, 60-frame pause).
module tb_pong_score_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] serve_n;
    logic [3:0] score_p1, score_p2;
    logic       ball_enable, serve_pulse, serve_dir, game_over;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int pulses;
    int dir_seen;

    pong_score_ctrl dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .serve_n     (serve_n),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .ball_enable (ball_enable),
        .serve_pulse (serve_pulse),
        .serve_dir   (serve_dir),
        .game_over   (game_over),
        .winner      (winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(2);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // press and release one button; btn=1 is player 1, btn=0 is player 2
    task automatic press_btn(input int btn);
        serve_n = (btn == 1) ? 2'b01 : 2'b10;
        step(1);
    endtask

    task automatic release_btn();
        serve_n = 2'b11;
        step(1);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0; serve_n = 2'b11;
        do_reset();
        check("rst_state", state, 0);
        check("rst_p1", score_p1, 0);
        check("rst_p2", score_p2, 0);
        check("rst_ball", ball_enable, 0);
        check("rst_pulse", serve_pulse, 0);
        check("rst_dir", serve_dir, 0);
        check("rst_winner", winner, 0);
        check("rst_over", game_over, 0);

        // player 1 launch from IDLE
        press_btn(1);
        check("idle_p1_pulse", serve_pulse, 1);
        check("idle_p1_dir", serve_dir, 1);
        check("idle_p1_state", state, 2);
        check("idle_p1_ball", ball_enable, 1);
        release_btn();
        check("idle_p1_pulse_off", serve_pulse, 0);

        // held miss_right scores once
        miss_right = 1'b1;
        step(1);
        check("pt_state", state, 3);
        check("pt_p1", score_p1, 1);
        check("pt_ball", ball_enable, 0);
        step(4);
        miss_right = 1'b0;
        check("pt_held_p1", score_p1, 1);
        press_btn(1);
        check("pt_press_ignored", serve_pulse, 0);
        release_btn();
        frames(59);
        check("pause_59", state, 3);
        frames(1);
        check("pause_60", state, 1);

        // server is player 2: player 1 button ignored
        press_btn(1);
        check("srv_wrong_pulse", serve_pulse, 0);
        check("srv_wrong_state", state, 1);
        release_btn();
        press_btn(0);
        check("srv_p2_pulse", serve_pulse, 1);
        check("srv_p2_dir", serve_dir, 0);
        check("srv_p2_state", state, 2);
        release_btn();

        // simultaneous misses: replay, server unchanged
        miss_left = 1'b1; miss_right = 1'b1;
        step(1);
        miss_left = 1'b0; miss_right = 1'b0;
        check("both_state", state, 1);
        check("both_p1", score_p1, 1);
        check("both_p2", score_p2, 0);
        miss_left = 1'b1; step(1); miss_left = 1'b0;
        miss_right = 1'b1; step(1); miss_right = 1'b0;
        check("serve_miss_p1", score_p1, 1);
        check("serve_miss_p2", score_p2, 0);
        press_btn(1);
        check("both_srv_p1_ignored", serve_pulse, 0);
        release_btn();
        press_btn(0);
        check("both_srv_p2_pulse", serve_pulse, 1);
        release_btn();

        // player 1 wins 7-0 from a fresh game
        do_reset();
        press_btn(1);
        release_btn();
        for (int pt = 1; pt <= 7; pt++) begin
            miss_right = 1'b1; step(1); miss_right = 1'b0;
            check("win_score", score_p1, pt);
            frames(60);
            if (pt < 7) begin
                check("win_serve_state", state, 1);
                press_btn(0);
                check("win_launch", serve_pulse, 1);
                release_btn();
            end
        end
        check("over_state", state, 4);
        check("over_flag", game_over, 1);
        check("over_winner", winner, 1);
        check("over_p1", score_p1, 7);
        check("over_p2", score_p2, 0);
        miss_left = 1'b1; step(2); miss_left = 1'b0;
        check("over_miss_p2", score_p2, 0);
        check("over_miss_state", state, 4);
        press_btn(0);
        check("clr_state", state, 0);
        check("clr_p1", score_p1, 0);
        check("clr_winner", winner, 0);
        check("clr_over", game_over, 0);
        check("clr_no_pulse", serve_pulse, 0);
        release_btn();
        check("clr_no_pulse2", serve_pulse, 0);
        check("clr_idle_stay", state, 0);

        // reset mid-pause
        press_btn(0);
        check("p2_launch_dir", serve_dir, 0);
        release_btn();
        miss_left = 1'b1; step(1); miss_left = 1'b0;
        check("ml_p2", score_p2, 1);
        frames(30);
        check("mid_pause", state, 3);
        reset = 1'b1; step(1); reset = 1'b0;
        check("midrst_state", state, 0);
        check("midrst_p2", score_p2, 0);
        frames(60);
        check("midrst_frames", state, 0);

        // both buttons held low for 1000 cycles: one launch, player 1 priority
        pulses = 0; dir_seen = 0;
        serve_n = 2'b00;
        for (int c = 0; c < 1000; c++) begin
            step(1);
            if (serve_pulse) begin
                pulses++;
                dir_seen = serve_dir;
            end
        end
        serve_n = 2'b11;
        check("hold_pulses", pulses, 1);
        check("hold_dir_p1", dir_seen, 1);
        check("hold_state", state, 2);

        // reset while a serve pulse is high
        do_reset();
        press_btn(1);
        reset = 1'b1; step(1); reset = 1'b0;
        check("rst_on_pulse", serve_pulse, 0);
        check("rst_on_pulse_st", state, 0);
        serve_n = 2'b11;
        step(1);
        miss_right = 1'b1; step(2); miss_right = 1'b0;
        check("idle_miss_p1", score_p1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
